// File: rtl/cpu_bus_arb.sv
// cpu_bus_arb: two-requester master that sequences one shared cs/rd/wr register bus.
// Define CPU_BUS_ARB_RR_EN for round-robin tie-breaking; default is fixed priority with req0 first.
module cpu_bus_arb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int HOLD_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] bus_addr,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic              bus_cs,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: reqN is a level held until doneN; gntN is high while N owns the bus
  // (SETUP..DONE); doneN is a one-cycle pulse; the command is captured at grant only.

  if (HOLD_CYC < 1) begin : g_hold_check
    $error("cpu_bus_arb: HOLD_CYC must be >= 1");
  end

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  hold_cnt;
  logic              owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              winner;
  logic              grant;
  logic              drive;
  logic              hold_end;

`ifdef CPU_BUS_ARB_RR_EN
  logic last_gnt;

  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = ~last_gnt;
    else if (req1)    winner = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)      last_gnt <= 1'b1;
    else if (grant) last_gnt <= winner;
  end
`else
  // req0 wins every tie, so req1 can starve while req0 stays high.
  assign winner = req1 & ~req0;
`endif

  assign hold_end = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    bus_cs    = 1'b0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    drive     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        bus_cs    = 1'b1;
        bus_addr  = lat_addr;
        drive     = lat_we;
        state_nxt = XFER;
      end
      XFER: begin
        bus_cs   = 1'b1;
        bus_addr = lat_addr;
        bus_rd   = ~lat_we;
        bus_wr   = lat_we;
        drive    = lat_we;
        if (hold_end) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      hold_cnt  <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      if (grant) begin
        owner     <= winner;
        lat_we    <= winner ? we1 : we0;
        lat_addr  <= winner ? addr1 : addr0;
        lat_wdata <= winner ? wdata1 : wdata0;
      end
      if (state == XFER && !hold_end) hold_cnt <= hold_cnt + CNT_W'(1);
      else                            hold_cnt <= '0;
      // Read data is sampled on the edge that closes the last strobe cycle.
      if (state == XFER && hold_end && !lat_we) begin
        if (owner) rdata1 <= bus_data;
        else       rdata0 <= bus_data;
      end
    end
  end

  assign bus_data  = drive ? lat_wdata : {DATA_W{1'bz}};
  assign busy      = (state != IDLE);
  assign gnt0      = busy & ~owner;
  assign gnt1      = busy & owner;
  assign done0     = (state == DONE) & ~owner;
  assign done1     = (state == DONE) & owner;
  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_bus_arb.sv
// tb_cpu_bus_arb: directed scenarios plus randomized traffic checked against a transaction-level model.
// Runs in either CPU_BUS_ARB_RR_EN configuration; a second instance uses HOLD_CYC=3.
module tb_cpu_bus_arb;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int HC     = 1;
  localparam int EXP_W  = 34 + DATA_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Main instance (HOLD_CYC=1)
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, done0, done1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] bus_addr;
  wire  [DATA_W-1:0] bus_data;
  logic              bus_cs, bus_rd, bus_wr, busy;
  logic [1:0]        state_dbg;

  cpu_bus_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOLD_CYC(HC)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_cs(bus_cs),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .busy(busy), .state_dbg(state_dbg)
  );

  // Register-file slave: drives read data during rd, 0 while cs is low, floats otherwise.
  logic [DATA_W-1:0] regs [16];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_val = '0;
  int                wr_cnt = 0;

  assign bus_data = !bus_cs ? {DATA_W{1'b0}} : (bus_rd ? regs[bus_addr] : {DATA_W{1'bz}});

  always @(posedge clk) begin
    if (pre_en) regs[pre_addr] <= pre_val;
    else if (bus_cs && bus_wr) begin
      regs[bus_addr] <= bus_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Second instance (HOLD_CYC=3) with a fixed read-only slave.
  logic              h_req0, h_req1, h_we0, h_we1;
  logic [ADDR_W-1:0] h_addr0, h_addr1;
  logic [DATA_W-1:0] h_wdata0, h_wdata1;
  logic              h_gnt0, h_gnt1, h_done0, h_done1;
  logic [DATA_W-1:0] h_rdata0, h_rdata1;
  logic [ADDR_W-1:0] h_bus_addr;
  wire  [DATA_W-1:0] h_bus_data;
  logic              h_bus_cs, h_bus_rd, h_bus_wr, h_busy;
  logic [1:0]        h_state_dbg;

  cpu_bus_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOLD_CYC(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0(h_req0), .req1(h_req1), .we0(h_we0), .we1(h_we1),
    .addr0(h_addr0), .addr1(h_addr1), .wdata0(h_wdata0), .wdata1(h_wdata1),
    .gnt0(h_gnt0), .gnt1(h_gnt1), .done0(h_done0), .done1(h_done1),
    .rdata0(h_rdata0), .rdata1(h_rdata1),
    .bus_addr(h_bus_addr), .bus_data(h_bus_data), .bus_cs(h_bus_cs),
    .bus_rd(h_bus_rd), .bus_wr(h_bus_wr), .busy(h_busy), .state_dbg(h_state_dbg)
  );

  assign h_bus_data = !h_bus_cs ? {DATA_W{1'b0}} :
                      (h_bus_rd ? ((h_bus_addr == 4'd7) ? 16'h1234 : 16'h0000) : {DATA_W{1'bz}});

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; h_req0 = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    pre_en = 1'b1; pre_addr = a; pre_val = v;
    step();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'hF; wdata0 = 16'hFFFF;
    step();
    step();
    do_reset();
    n_cmp++; if (bus_cs !== 1'b0)  begin n_bad++; $display("FAIL reset_cs: got %b want 0", bus_cs); end
    n_cmp++; if (bus_rd !== 1'b0)  begin n_bad++; $display("FAIL reset_rd: got %b want 0", bus_rd); end
    n_cmp++; if (bus_wr !== 1'b0)  begin n_bad++; $display("FAIL reset_wr: got %b want 0", bus_wr); end
    n_cmp++; if (bus_addr !== 4'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus_addr); end
    n_cmp++; if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt_done: got %b want 0000", {gnt0, gnt1, done0, done1}); end
    n_cmp++; if (rdata0 !== 16'h0) begin n_bad++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
    n_cmp++; if (rdata1 !== 16'h0) begin n_bad++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (bus_data !== 16'h0) begin n_bad++; $display("FAIL reset_data_float: got %h want 0", bus_data); end
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 16'hA5A5;
    step();
    n_cmp++; if ({bus_cs, bus_rd, bus_wr} !== 3'b100) begin n_bad++; $display("FAIL wr_setup_strobes: got %b want 100", {bus_cs, bus_rd, bus_wr}); end
    n_cmp++; if (bus_addr !== 4'd3) begin n_bad++; $display("FAIL wr_setup_addr: got %h want 3", bus_addr); end
    n_cmp++; if (bus_data !== 16'hA5A5) begin n_bad++; $display("FAIL wr_setup_data: got %h want a5a5", bus_data); end
    n_cmp++; if ({gnt0, gnt1, busy} !== 3'b101) begin n_bad++; $display("FAIL wr_setup_gnt: got %b want 101", {gnt0, gnt1, busy}); end
    step();
    n_cmp++; if ({bus_cs, bus_rd, bus_wr} !== 3'b101) begin n_bad++; $display("FAIL wr_xfer_strobes: got %b want 101", {bus_cs, bus_rd, bus_wr}); end
    n_cmp++; if (bus_data !== 16'hA5A5) begin n_bad++; $display("FAIL wr_xfer_data: got %h want a5a5", bus_data); end
    step();
    n_cmp++; if ({done0, done1, gnt0} !== 3'b101) begin n_bad++; $display("FAIL wr_done: got %b want 101", {done0, done1, gnt0}); end
    n_cmp++; if ({bus_cs, bus_wr} !== 2'b00) begin n_bad++; $display("FAIL wr_done_strobes: got %b want 00", {bus_cs, bus_wr}); end
    n_cmp++; if (bus_data !== 16'h0) begin n_bad++; $display("FAIL wr_done_float: got %h want 0", bus_data); end
    n_cmp++; if (regs[3] !== 16'hA5A5) begin n_bad++; $display("FAIL wr_reg3: got %h want a5a5", regs[3]); end
    req0 = 1'b0;
    step();
    n_cmp++; if ({busy, gnt0, done0} !== 3'b000) begin n_bad++; $display("FAIL wr_idle: got %b want 000", {busy, gnt0, done0}); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3; wdata0 = 16'h0000;
    step();
    step();
    n_cmp++; if ({bus_rd, bus_wr} !== 2'b10) begin n_bad++; $display("FAIL rd_xfer_strobes: got %b want 10", {bus_rd, bus_wr}); end
    n_cmp++; if (bus_data !== 16'hA5A5) begin n_bad++; $display("FAIL rd_no_contention: got %h want a5a5", bus_data); end
    step();
    n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL rd_done0: got %b want 1", done0); end
    n_cmp++; if (rdata0 !== 16'hA5A5) begin n_bad++; $display("FAIL rd_rdata0: got %h want a5a5", rdata0); end
    n_cmp++; if (rdata1 !== 16'h0) begin n_bad++; $display("FAIL rd_rdata1_held: got %h want 0", rdata1); end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_arbitration();
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
`ifdef CPU_BUS_ARB_RR_EN
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 4'd1; addr1 = 4'd2;
    for (int k = 0; k < 40 && got_q.size() < 4; k++) begin
      step();
      n_cmp++; if (gnt0 && gnt1) begin n_bad++; $display("FAIL arb_gnt_overlap: got gnt0=%b gnt1=%b want one-hot", gnt0, gnt1); end
      n_cmp++; if (bus_rd && bus_wr) begin n_bad++; $display("FAIL arb_rd_wr: got rd=%b wr=%b want not both", bus_rd, bus_wr); end
      if (done0) got_q.push_back(1'b0);
      if (done1) got_q.push_back(1'b1);
      if (got_q.size() >= 4) begin req0 = 1'b0; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL arb_count: got %0d dones want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL arb_owner%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
    end
    repeat (4) step();
  endtask

  task automatic test_hold3();
    h_req0 = 1'b1; h_we0 = 1'b0; h_addr0 = 4'd7; h_wdata0 = 16'h0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_cmp++; if (h_bus_rd !== (k >= 2 && k <= 4)) begin n_bad++; $display("FAIL h3_rd_c%0d: got %b want %b", k, h_bus_rd, (k >= 2 && k <= 4)); end
      n_cmp++; if (h_bus_cs !== (k >= 1 && k <= 4)) begin n_bad++; $display("FAIL h3_cs_c%0d: got %b want %b", k, h_bus_cs, (k >= 1 && k <= 4)); end
      n_cmp++; if (h_done0 !== (k == 5)) begin n_bad++; $display("FAIL h3_done_c%0d: got %b want %b", k, h_done0, (k == 5)); end
      n_cmp++; if (h_bus_wr !== 1'b0) begin n_bad++; $display("FAIL h3_wr_c%0d: got %b want 0", k, h_bus_wr); end
      if (k >= 2 && k <= 4) begin
        n_cmp++; if (h_bus_data !== 16'h1234) begin n_bad++; $display("FAIL h3_data_c%0d: got %h want 1234", k, h_bus_data); end
      end
      if (k == 5) begin
        n_cmp++; if (h_rdata0 !== 16'h1234) begin n_bad++; $display("FAIL h3_rdata0: got %h want 1234", h_rdata0); end
        h_req0 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic saw_done;
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 16'h5A5A;
    step();
    step();
    n_cmp++; if (bus_wr !== 1'b1) begin n_bad++; $display("FAIL rm_xfer_wr: got %b want 1", bus_wr); end
    reset = 1'b1; req0 = 1'b0;
    step();
    n_cmp++; if ({bus_cs, bus_rd, bus_wr} !== 3'b000) begin n_bad++; $display("FAIL rm_strobes: got %b want 000", {bus_cs, bus_rd, bus_wr}); end
    n_cmp++; if ({gnt0, gnt1, done0, done1, busy} !== 5'b0) begin n_bad++; $display("FAIL rm_gnt_done: got %b want 00000", {gnt0, gnt1, done0, done1, busy}); end
    n_cmp++; if (bus_data !== 16'h0) begin n_bad++; $display("FAIL rm_float: got %h want 0", bus_data); end
    reset = 1'b0;
    base = wr_cnt;
    saw_done = 1'b0;
    repeat (5) begin
      step();
      if (done0 || done1 || busy) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL rm_no_done: got activity=%b want 0", saw_done); end
    n_cmp++; if (wr_cnt != base) begin n_bad++; $display("FAIL rm_no_write: got %0d writes want %0d", wr_cnt, base); end
  endtask

  task automatic test_latch();
    do_reset();
    preload(4'd2, 16'h0BAD);
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd9; wdata1 = 16'h1357;
    step();
    n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_bad++; $display("FAIL lat_gnt1: got %b want 01", {gnt0, gnt1}); end
    req1 = 1'b0; we1 = 1'b0; addr1 = 4'd2; wdata1 = 16'hFFFF;
    step();
    n_cmp++; if (bus_wr !== 1'b1) begin n_bad++; $display("FAIL lat_wr: got %b want 1", bus_wr); end
    n_cmp++; if (bus_addr !== 4'd9) begin n_bad++; $display("FAIL lat_addr: got %h want 9", bus_addr); end
    n_cmp++; if (bus_data !== 16'h1357) begin n_bad++; $display("FAIL lat_data: got %h want 1357", bus_data); end
    step();
    n_cmp++; if ({done0, done1, gnt1} !== 3'b011) begin n_bad++; $display("FAIL lat_done1: got %b want 011", {done0, done1, gnt1}); end
    step();
    n_cmp++; if (regs[9] !== 16'h1357) begin n_bad++; $display("FAIL lat_reg9: got %h want 1357", regs[9]); end
    n_cmp++; if (regs[2] !== 16'h0BAD) begin n_bad++; $display("FAIL lat_reg2: got %h want 0bad", regs[2]); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lat_idle: got %b want 0", busy); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] exp_reg [16];
    logic [DATA_W-1:0] exp_rd [2];
    logic [EXP_W-1:0]  exp_q[$];
    logic [EXP_W-1:0]  head;
    logic              act [2];
    logic              granted [2];
    logic              c_we [2];
    logic [ADDR_W-1:0] c_addr [2];
    logic [DATA_W-1:0] c_wdata [2];
    logic              w, e_own, e_we;
    logic [DATA_W-1:0] e_data;
    logic              exp_d0, exp_d1, exp_g0, exp_g1;
    int                idle_at, dcyc;
    int                ncyc = 800;
`ifdef CPU_BUS_ARB_RR_EN
    logic              last = 1'b1;
`endif
    do_reset();
    for (int a = 0; a < 16; a++) begin
      exp_reg[a] = 16'($urandom);
      preload(4'(a), exp_reg[a]);
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    act[0] = 1'b0; act[1] = 1'b0; granted[0] = 1'b0; granted[1] = 1'b0;
    idle_at = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      exp_d0 = 1'b0; exp_d1 = 1'b0; exp_g0 = 1'b0; exp_g1 = 1'b0;
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        dcyc = int'(head[EXP_W-1 -: 32]);
        e_own = head[DATA_W+1];
        e_we = head[DATA_W];
        e_data = head[DATA_W-1:0];
        if (cyc >= dcyc - 1 - HC) begin exp_g0 = !e_own; exp_g1 = e_own; end
        if (cyc == dcyc) begin
          exp_d0 = !e_own; exp_d1 = e_own;
          if (!e_we) exp_rd[e_own] = e_data;
          act[e_own] = 1'b0;
          granted[e_own] = 1'b0;
          void'(exp_q.pop_front());
        end
      end
      n_cmp++; if ({done0, done1} !== {exp_d0, exp_d1}) begin n_bad++; $display("FAIL rand_done cyc%0d: got %b%b want %b%b", cyc, done0, done1, exp_d0, exp_d1); end
      n_cmp++; if ({gnt0, gnt1} !== {exp_g0, exp_g1}) begin n_bad++; $display("FAIL rand_gnt cyc%0d: got %b%b want %b%b", cyc, gnt0, gnt1, exp_g0, exp_g1); end
      n_cmp++; if (busy !== (cyc < idle_at)) begin n_bad++; $display("FAIL rand_busy cyc%0d: got %b want %b", cyc, busy, (cyc < idle_at)); end
      n_cmp++; if (rdata0 !== exp_rd[0]) begin n_bad++; $display("FAIL rand_rdata0 cyc%0d: got %h want %h", cyc, rdata0, exp_rd[0]); end
      n_cmp++; if (rdata1 !== exp_rd[1]) begin n_bad++; $display("FAIL rand_rdata1 cyc%0d: got %h want %h", cyc, rdata1, exp_rd[1]); end
      n_cmp++; if (bus_rd && bus_wr) begin n_bad++; $display("FAIL rand_rd_wr cyc%0d: got rd=1 wr=1 want not both", cyc); end

      for (int r = 0; r < 2; r++) begin
        if (!act[r] && cyc < ncyc - 20 && $urandom_range(0, 2) == 0) begin
          act[r] = 1'b1;
          c_we[r] = 1'($urandom);
          c_addr[r] = 4'($urandom);
          c_wdata[r] = 16'($urandom);
        end
      end
      if (act[0] && !granted[0]) begin req0 = 1'b1; we0 = c_we[0]; addr0 = c_addr[0]; wdata0 = c_wdata[0]; end
      else begin req0 = act[0] & 1'($urandom); we0 = 1'($urandom); addr0 = 4'($urandom); wdata0 = 16'($urandom); end
      if (act[1] && !granted[1]) begin req1 = 1'b1; we1 = c_we[1]; addr1 = c_addr[1]; wdata1 = c_wdata[1]; end
      else begin req1 = act[1] & 1'($urandom); we1 = 1'($urandom); addr1 = 4'($urandom); wdata1 = 16'($urandom); end

      if (cyc >= idle_at && (req0 || req1)) begin
`ifdef CPU_BUS_ARB_RR_EN
        w = (req0 && req1) ? ~last : req1;
        last = w;
`else
        w = req1 && !req0;
`endif
        granted[w] = 1'b1;
        if (c_we[w]) begin
          exp_reg[c_addr[w]] = c_wdata[w];
          e_data = c_wdata[w];
        end else begin
          e_data = exp_reg[c_addr[w]];
        end
        exp_q.push_back({32'(cyc + 2 + HC), w, c_we[w], e_data});
        idle_at = cyc + 3 + HC;
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_drain: got %0d outstanding want 0", exp_q.size()); end
    for (int a = 0; a < 16; a++) begin
      n_cmp++; if (regs[a] !== exp_reg[a]) begin n_bad++; $display("FAIL rand_reg%0d: got %h want %h", a, regs[a], exp_reg[a]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    h_req0 = 1'b0; h_req1 = 1'b0; h_we0 = 1'b0; h_we1 = 1'b0;
    h_addr0 = '0; h_addr1 = '0; h_wdata0 = '0; h_wdata1 = '0;
    test_reset();
    test_write_read();
    test_arbitration();
    test_hold3();
    test_reset_mid();
    test_latch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
